// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared widths, FSM state and op encodings for the multiply/divide unit
package ex_muldiv_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;
    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_MULT = 1'b1;
endpackage

// File: rtl/ex_muldiv_sign.sv
// ex_muldiv_sign: two-lane conditional two's-complement negation (magnitude extraction and sign fix-up)
module ex_muldiv_sign
    import ex_muldiv_pkg::*;
#(
    parameter int W = DEFAULT_DATA_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         neg_a,
    input  logic         neg_b,
    output logic [W-1:0] fix_a,
    output logic [W-1:0] fix_b
);
    assign fix_a = neg_a ? -a : a;
    assign fix_b = neg_b ? -b : b;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative W-cycle multiply / restoring divide on magnitudes with sign correction
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    is_annul,
    input  logic                    is_signed,
    input  logic                    op,
    input  logic [DATA_WIDTH-1:0]   operand1,
    input  logic [DATA_WIDTH-1:0]   operand2,
    output logic                    busy,
    output logic                    is_ended,
    output logic                    div_by_zero,
    output logic [RESULT_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_r, neg_q, neg_r;
    logic [W-1:0]  hi, lo, b;
    logic          sign1, sign2, ge;
    logic [W-1:0]  mag1, mag2, hi_n, lo_n;
    logic [W:0]    shifted, sum;
    logic [2*W-1:0] lane_a, lane_b, fix_a, fix_b, result_n;

    assign sign1 = is_signed & operand1[W-1];
    assign sign2 = is_signed & operand2[W-1];

    ex_muldiv_sign #(.W(W)) u_operands (
        .a(operand1), .b(operand2), .neg_a(sign1), .neg_b(sign2), .fix_a(mag1), .fix_b(mag2)
    );

    // hi/lo hold {remainder, quotient} for divide and {partial, multiplier} for multiply
    always_comb begin
        shifted  = {hi, lo[W-1]};
        ge       = shifted >= {1'b0, b};
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        hi_n     = op_r == OP_MULT ? sum[W:1] : W'(ge ? shifted - {1'b0, b} : shifted);
        lo_n     = op_r == OP_MULT ? {sum[0], lo[W-1:1]} : {lo[W-2:0], ge};
        lane_a   = op_r == OP_MULT ? {hi_n, lo_n} : {{W{1'b0}}, lo_n};
        lane_b   = {hi_n, {W{1'b0}}};
        result_n = op_r == OP_MULT ? fix_a : (fix_b | {{W{1'b0}}, fix_a[W-1:0]});
    end

    ex_muldiv_sign #(.W(2 * W)) u_result (
        .a(lane_a), .b(lane_b), .neg_a(neg_q), .neg_b(neg_r), .fix_a(fix_a), .fix_b(fix_b)
    );

    always_ff @(posedge clock) begin
        if (reset || is_annul) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            is_ended    <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    op_r  <= op;
                    neg_q <= sign1 ^ sign2;
                    neg_r <= sign1;
                    hi    <= '0;
                    lo    <= op == OP_MULT ? mag2 : mag1;
                    b     <= op == OP_MULT ? mag1 : mag2;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= (op == OP_DIV && operand2 == '0) ? ST_DIVZERO : ST_RUN;
                end
                ST_DIVZERO: begin
                    state       <= ST_DONE;
                    is_ended    <= 1'b1;
                    div_by_zero <= 1'b1;
                end
                ST_RUN: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state    <= ST_DONE;
                        is_ended <= 1'b1;
                        result   <= result_n;
                    end
                end
                ST_DONE: if (!start) begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    is_ended    <= 1'b0;
                    div_by_zero <= 1'b0;
                    result      <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv at W=32 and W=8
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, is_annul;
    logic        start, is_signed, op;
    logic [31:0] operand1, operand2;
    logic        busy, is_ended, div_by_zero;
    logic [63:0] result;
    logic        start8, is_signed8, op8;
    logic [7:0]  operand1_8, operand2_8;
    logic        busy8, is_ended8, div_by_zero8;
    logic [15:0] result8;

    exp_t q32[$];
    exp_t q8[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic ended_q = 1'b0;
    logic ended8_q = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ex_muldiv dut (
        .clock(clock), .reset(reset), .start(start), .is_annul(is_annul), .is_signed(is_signed),
        .op(op), .operand1(operand1), .operand2(operand2), .busy(busy), .is_ended(is_ended),
        .div_by_zero(div_by_zero), .result(result)
    );

    ex_muldiv #(.DATA_WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_annul(is_annul), .is_signed(is_signed8),
        .op(op8), .operand1(operand1_8), .operand2(operand2_8), .busy(busy8), .is_ended(is_ended8),
        .div_by_zero(div_by_zero8), .result(result8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (is_ended === 1'b1 && !ended_q) begin
            if (q32.size() == 0) begin
                checks++;
                $display("FAIL unexpected_end32: got is_ended=1 expected no completion");
            end else begin
                e = q32.pop_front();
                check("result32", result, e.res);
                check("div_by_zero32", {63'b0, div_by_zero}, {63'b0, e.dz});
                check("latency32", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
        ended_q = (is_ended === 1'b1);
    end

    always @(negedge clock) begin
        exp_t e;
        if (is_ended8 === 1'b1 && !ended8_q) begin
            if (q8.size() == 0) begin
                checks++;
                $display("FAIL unexpected_end8: got is_ended=1 expected no completion");
            end else begin
                e = q8.pop_front();
                check("result8", {48'b0, result8}, e.res);
                check("div_by_zero8", {63'b0, div_by_zero8}, {63'b0, e.dz});
                check("latency8", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
        ended8_q = (is_ended8 === 1'b1);
    end

    task automatic wait_end32();
        for (int i = 0; i < 60 && is_ended !== 1'b1; i++) @(negedge clock);
        if (is_ended !== 1'b1) begin
            checks++;
            $display("FAIL timeout32: got is_ended=%b expected 1 within 60 cycles", is_ended);
        end
    endtask

    task automatic run32(input logic o, input logic s, input logic [31:0] a, input logic [31:0] d,
                         input logic [63:0] res, input logic dz);
        @(negedge clock);
        op = o; is_signed = s; operand1 = a; operand2 = d; start = 1'b1;
        q32.push_back('{res, dz, dz ? 2 : 33, cyc});
        @(negedge clock);
        check("busy_running", {63'b0, busy}, 64'd1);
        check("result_hidden", result, 64'd0);
        operand1 = $urandom; operand2 = $urandom; op = ~o; is_signed = ~s;
        wait_end32();
        @(negedge clock);
        @(negedge clock);
        check("hold_ended", {63'b0, is_ended}, 64'd1);
        check("hold_result", result, res);
        start = 1'b0;
        @(negedge clock);
        check("idle_flags", {61'b0, busy, is_ended, div_by_zero}, 64'd0);
        check("idle_result", result, 64'd0);
    endtask

    task automatic run8(input logic o, input logic s, input logic [7:0] a, input logic [7:0] d,
                        input logic [15:0] res);
        @(negedge clock);
        op8 = o; is_signed8 = s; operand1_8 = a; operand2_8 = d; start8 = 1'b1;
        q8.push_back('{{48'b0, res}, 1'b0, 9, cyc});
        @(negedge clock);
        operand1_8 = 8'($urandom); operand2_8 = 8'($urandom);
        for (int i = 0; i < 30 && is_ended8 !== 1'b1; i++) @(negedge clock);
        if (is_ended8 !== 1'b1) begin
            checks++;
            $display("FAIL timeout8: got is_ended=%b expected 1 within 30 cycles", is_ended8);
        end
        start8 = 1'b0;
        @(negedge clock);
        check("idle8", {47'b0, busy8, result8}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; is_annul = 1'b0; start = 1'b0; is_signed = 1'b0; op = OP_DIV;
        operand1 = '0; operand2 = '0;
        start8 = 1'b0; is_signed8 = 1'b0; op8 = OP_DIV; operand1_8 = '0; operand2_8 = '0;
        repeat (3) @(negedge clock);
        check("reset_flags", {61'b0, busy, is_ended, div_by_zero}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_flags8", {61'b0, busy8, is_ended8, div_by_zero8}, 64'd0);
        reset = 1'b0;

        run32(OP_DIV,  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b0);
        run32(OP_DIV,  1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run32(OP_MULT, 1'b1, 32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1, 1'b0);
        run32(OP_DIV,  1'b0, 32'd5,          32'd0,          64'd0,                 1'b1);
        run32(OP_DIV,  1'b1, 32'hFFFFFFFB,   32'd0,          64'd0,                 1'b1);
        run32(OP_DIV,  1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0);
        run32(OP_DIV,  1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0);
        run32(OP_DIV,  1'b0, 32'd7,          32'd100,        64'h00000007_00000000, 1'b0);
        run32(OP_DIV,  1'b0, 32'hFFFFFFFF,   32'h10,         64'h0000000F_0FFFFFFF, 1'b0);
        run32(OP_MULT, 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001, 1'b0);
        run32(OP_MULT, 1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 1'b0);
        run32(OP_MULT, 1'b0, 32'h12345678,   32'd0,          64'd0,                 1'b0);

        // abort mid-run: no completion expected, then a clean rerun
        @(negedge clock);
        op = OP_DIV; is_signed = 1'b0; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
        repeat (10) @(negedge clock);
        is_annul = 1'b1; start = 1'b0;
        @(negedge clock);
        is_annul = 1'b0;
        check("annul_flags", {61'b0, busy, is_ended, div_by_zero}, 64'd0);
        check("annul_result", result, 64'd0);
        repeat (40) @(negedge clock);
        check("annul_no_end", {63'b0, is_ended}, 64'd0);
        run32(OP_DIV, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

        // reset mid-run with start held through it
        @(negedge clock);
        op = OP_MULT; is_signed = 1'b0; operand1 = 32'd6; operand2 = 32'd7; start = 1'b1;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_flags", {61'b0, busy, is_ended, div_by_zero}, 64'd0);
        check("midreset_result", result, 64'd0);
        reset = 1'b0;
        q32.push_back('{64'd42, 1'b0, 33, cyc});
        wait_end32();
        start = 1'b0;
        @(negedge clock);
        check("postreset_idle", {61'b0, busy, is_ended, div_by_zero}, 64'd0);

        run8(OP_MULT, 1'b0, 8'd200,  8'd200,  16'h9C40);
        run8(OP_DIV,  1'b1, 8'h80,   8'hFF,   16'h0080);
        run8(OP_MULT, 1'b1, 8'h80,   8'h80,   16'h4000);
        run8(OP_MULT, 1'b1, 8'hF9,   8'h03,   16'hFFEB);

        repeat (5) @(negedge clock);
        check("queues_drained", 64'(q32.size() + q8.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand width W; SHALL be an even value of at least 4.
REQ-002 Parameter RESULT_WIDTH, default 2*DATA_WIDTH, result width; SHALL NOT be overridden.
REQ-003 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; held high by EX until is_ended is seen, then dropped.
REQ-006 is_annul  input  1  abort the current operation.
REQ-007 is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 op  input  1  0 = divide, 1 = multiply.
REQ-009 operand1  input  W  dividend or multiplicand.
REQ-010 operand2  input  W  divisor or multiplier.
REQ-011 busy  output  1  high in RUN, DIVZERO and DONE.
REQ-012 is_ended  output  1  result valid, high only in DONE.
REQ-013 div_by_zero  output  1  high in DONE when the finished operation was a divide with operand2 == 0.
REQ-014 result  output  2W  {hi, lo}: divide = {remainder, quotient}; multiply = full product.

Function
REQ-015 FSM states: IDLE, DIVZERO, RUN, DONE. Encodings are shared constants.
REQ-016 IDLE: start=1 and is_annul=0 captures op, is_signed and operand magnitudes, and clears the iteration counter. Next state is DIVZERO if op=0 and operand2==0, otherwise RUN.
REQ-017 Operands SHALL be sampled only on the IDLE acceptance edge. Later changes to the inputs SHALL be ignored.
REQ-018 RUN: exactly W cycles, one result bit per cycle. Divide uses restoring shift-subtract on magnitudes. Multiply uses shift-add on magnitudes.
REQ-019 After the W-th RUN cycle the state SHALL go to DONE. With start sampled at edge k, is_ended SHALL be high from edge k+W+1.
REQ-020 DIVZERO: one cycle, then DONE with result=0 and div_by_zero=1. is_ended is therefore high from edge k+2.
REQ-021 Signed divide: quotient is negated when the operand signs differ, and the remainder takes the dividend's sign. Signed multiply: the product is negated when the operand signs differ.
REQ-022 Signed divide of the most-negative value by -1 SHALL give quotient = most-negative value and remainder = 0. No flag is raised.
REQ-023 DONE: result and is_ended SHALL hold while start=1. When start=0 the state SHALL return to IDLE on the next edge, and is_ended and div_by_zero SHALL clear.
REQ-024 start=1 in DONE SHALL NOT begin a new operation. A new operation requires passing through IDLE.
REQ-025 is_annul=1 in any state SHALL force IDLE on the next edge, with is_ended=0 and result=0. Annul takes priority over start and over completion.
REQ-026 start is ignored in RUN and DIVZERO.
REQ-027 result SHALL read 0 in IDLE, RUN and DIVZERO, so no partial value is ever exposed.

Reset
REQ-028 reset=1 SHALL, on the next edge, force IDLE and set busy=0, is_ended=0, div_by_zero=0 and result=0, regardless of state.
REQ-029 Reset mid-operation SHALL discard all state. The first start after reset SHALL behave as a fresh operation.

Structure
REQ-030 The FSM state encodings, the op encodings (DIV, MULT) and the default DATA_WIDTH SHALL live in the shared macro/constant file. No local literals SHALL be used for them.
REQ-031 Magnitude extraction and sign fix-up SHALL be a sub-module ex_muldiv_sign (combinational, parametrised on W), instantiated twice: once for operands, once for result correction.
REQ-032 The iteration counter width SHALL be clog2(W)+1.

Verification
REQ-033 W=32, unsigned divide 100/7, start held -> is_ended at start+33 cycles, result {0x00000002, 0x0000000E}.
REQ-034 W=32, signed divide -7/2 -> result {0xFFFFFFFF, 0xFFFFFFFD}, div_by_zero=0.
REQ-035 W=32, signed multiply -3*5 -> result 0xFFFFFFFF_FFFFFFF1; W=8, unsigned 200*200 -> result 0x9C40.
REQ-036 Divide by zero (operand1=5, operand2=0) -> is_ended at start+2, result 0, div_by_zero=1; start dropped -> IDLE next edge, flags clear.
REQ-037 is_annul pulsed on RUN cycle 10 -> is_ended never rises, IDLE next edge; a following start runs a full W cycles with the correct result.
REQ-038 reset asserted on RUN cycle 5 -> all outputs 0 next edge; start held through reset is accepted on the first edge after reset deasserts.
